// File: rtl/multimode_reg.sv
// multimode_reg: WIDTH-bit register with hold/load/JK/toggle/shift/inc/dec modes,
// registered serial-out and terminal-count flags for chaining.
`default_nettype none

module multimode_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               SAT       = 1'b0
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             SCLR,
    input  logic             EN,
    input  logic [2:0]       MODE,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    input  logic             SI,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] nQ,
    output logic             SO,
    output logic             TC
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_JK   = 3'b010;
    localparam logic [2:0] MODE_TOG  = 3'b011;
    localparam logic [2:0] MODE_SHL  = 3'b100;
    localparam logic [2:0] MODE_SHR  = 3'b101;
    localparam logic [2:0] MODE_INC  = 3'b110;
    localparam logic [2:0] MODE_DEC  = 3'b111;

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    logic [WIDTH-1:0] q_reg;
    logic             so_reg;
    logic             tc_reg;

    logic [WIDTH-1:0] q_next;
    logic             so_next;
    logic             tc_next;

    logic [WIDTH-1:0] shl_val;
    logic [WIDTH-1:0] shr_val;
    logic             shl_out;
    logic             shr_out;

    // A 1-bit register has no interior bits, so both shifts collapse to Q<=SI.
    generate
        if (WIDTH == 1) begin : g_shift_narrow
            assign shl_val = SI;
            assign shr_val = SI;
            assign shl_out = q_reg[0];
            assign shr_out = q_reg[0];
        end else begin : g_shift_wide
            assign shl_val = {q_reg[WIDTH-2:0], SI};
            assign shr_val = {SI, q_reg[WIDTH-1:1]};
            assign shl_out = q_reg[WIDTH-1];
            assign shr_out = q_reg[0];
        end
    endgenerate

    always_comb begin
        q_next  = q_reg;
        so_next = so_reg;
        tc_next = 1'b0;
        if (SCLR) begin
            q_next  = RESET_VAL;
            so_next = 1'b0;
        end else if (EN) begin
            case (MODE)
                MODE_HOLD: q_next = q_reg;
                MODE_LOAD: q_next = D;
                MODE_JK:   q_next = (J & ~q_reg) | (~K & q_reg);
                MODE_TOG:  q_next = q_reg ^ D;
                MODE_SHL: begin
                    q_next  = shl_val;
                    so_next = shl_out;
                end
                MODE_SHR: begin
                    q_next  = shr_val;
                    so_next = shr_out;
                end
                MODE_INC: begin
                    if (q_reg == ALL_ONES) begin
                        tc_next = 1'b1;
                        q_next  = SAT ? q_reg : '0;
                    end else begin
                        q_next = q_reg + ONE;
                    end
                end
                MODE_DEC: begin
                    if (q_reg == '0) begin
                        tc_next = 1'b1;
                        q_next  = SAT ? q_reg : ALL_ONES;
                    end else begin
                        q_next = q_reg - ONE;
                    end
                end
                default: q_next = q_reg;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            q_reg  <= RESET_VAL;
            so_reg <= 1'b0;
            tc_reg <= 1'b0;
        end else begin
            q_reg  <= q_next;
            so_reg <= so_next;
            tc_reg <= tc_next;
        end
    end

    assign Q  = q_reg;
    assign nQ = ~q_reg;
    assign SO = so_reg;
    assign TC = tc_reg;

endmodule

`default_nettype wire
